// File: rtl/b2tt_trigger_pulser_pkg.sv
// b2tt_trigger_pulser_pkg: FSM state encoding and default widths shared by the trigger pulser
package b2tt_trigger_pulser_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, PULSE = 2'd2, HOLDOFF = 2'd3} state_t;
  localparam int DEF_DELAY_BITS   = 16;
  localparam int DEF_WIDTH_BITS   = 8;
  localparam int DEF_HOLDOFF_BITS = 16;
  localparam int DEF_COUNT_BITS   = 32;
  localparam int DEF_DROP_BITS    = 16;
  localparam int DEF_PHASE_BITS   = 16;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/b2tt_trigger_pulser_frame_phase_counter.sv
// frame_phase_counter: cycles since the last frame9 marker, saturating at all-ones
//   clock, reset (async, active-high), frame9 marker in; phase out.
//   phase reads 0 in the frame9 cycle itself so a coincident trigger sees phase 0.
module frame_phase_counter #(
  parameter int PHASE_BITS = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  frame9,
  output logic [PHASE_BITS-1:0] phase
);
  logic [PHASE_BITS-1:0] phase_q;
  assign phase = frame9 ? '0 : phase_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) phase_q <= '0;
    else phase_q <= frame9 ? PHASE_BITS'(1) : ((&phase_q) ? phase_q : phase_q + 1'b1);
endmodule

// File: rtl/b2tt_trigger_pulser.sv
// b2tt_trigger_pulser: one delayed, programmable-width laser pulse per accepted b2tt trigger
//   in : clock, reset (async, active-high), trg, frame9, delay, width, holdoff,
//        gate_start, gate_end, clear_counts
//   out: pulse (registered), busy (FSM not IDLE), accepted_count (wraps),
//        dropped_count (saturates)
//   FRAME_GATE_EN: when defined, triggers are accepted only inside the frame phase
//   window gate_start..gate_end; otherwise frame9 and the gate inputs are ignored.
module b2tt_trigger_pulser
  import b2tt_trigger_pulser_pkg::*;
#(
  parameter int DELAY_BITS   = DEF_DELAY_BITS,
  parameter int WIDTH_BITS   = DEF_WIDTH_BITS,
  parameter int HOLDOFF_BITS = DEF_HOLDOFF_BITS,
  parameter int COUNT_BITS   = DEF_COUNT_BITS,
  parameter int DROP_BITS    = DEF_DROP_BITS,
  parameter int PHASE_BITS   = DEF_PHASE_BITS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    trg,
  input  logic                    frame9,
  input  logic [DELAY_BITS-1:0]   delay,
  input  logic [WIDTH_BITS-1:0]   width,
  input  logic [HOLDOFF_BITS-1:0] holdoff,
  input  logic [PHASE_BITS-1:0]   gate_start,
  input  logic [PHASE_BITS-1:0]   gate_end,
  input  logic                    clear_counts,
  output logic                    pulse,
  output logic                    busy,
  output logic [COUNT_BITS-1:0]   accepted_count,
  output logic [DROP_BITS-1:0]    dropped_count
);
  localparam int CW = max3(DELAY_BITS, WIDTH_BITS, HOLDOFF_BITS);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WIDTH_BITS-1:0] width_q, width_n, width_eff;
  logic [HOLDOFF_BITS-1:0] holdoff_q, holdoff_n;
  logic in_gate, accept, drop;
`ifdef FRAME_GATE_EN
  logic [PHASE_BITS-1:0] phase;
  frame_phase_counter #(.PHASE_BITS(PHASE_BITS)) u_phase (
    .clock(clock), .reset(reset), .frame9(frame9), .phase(phase)
  );
  assign in_gate = phase >= gate_start && phase <= gate_end;
`else
  logic unused_gate;
  assign unused_gate = ^{frame9, gate_start, gate_end};
  assign in_gate = 1'b1;
`endif
  assign width_eff = (width == '0) ? WIDTH_BITS'(1) : width;
  assign accept = trg && in_gate && state == IDLE;
  assign drop = trg && !accept;
  assign busy = state != IDLE;
  // One down-counter is reused for delay, width and holdoff; each phase ends when it reads 1.
  always_comb begin
    state_n = state;
    cnt_n = cnt - 1'b1;
    width_n = width_q;
    holdoff_n = holdoff_q;
    case (state)
      IDLE: begin
        cnt_n = cnt;
        if (accept) begin
          width_n = width_eff;
          holdoff_n = holdoff;
          state_n = (delay == '0) ? PULSE : DELAY;
          cnt_n = (delay == '0) ? CW'(width_eff) : CW'(delay);
        end
      end
      DELAY: if (cnt == CW'(1)) begin
        state_n = PULSE;
        cnt_n = CW'(width_q);
      end
      PULSE: if (cnt == CW'(1)) begin
        state_n = (holdoff_q == '0) ? IDLE : HOLDOFF;
        cnt_n = CW'(holdoff_q);
      end
      default: if (cnt == CW'(1)) state_n = IDLE;
    endcase
  end
  // pulse is the registered PULSE state, which supplies the extra cycle of latency.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      width_q <= '0;
      holdoff_q <= '0;
      pulse <= 1'b0;
      accepted_count <= '0;
      dropped_count <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      width_q <= width_n;
      holdoff_q <= holdoff_n;
      pulse <= state == PULSE;
      accepted_count <= clear_counts ? '0 : accepted_count + COUNT_BITS'(accept);
      dropped_count <= clear_counts ? '0 : dropped_count + DROP_BITS'(drop && !(&dropped_count));
    end
endmodule

// File: tb/tb_b2tt_trigger_pulser.sv
// tb_b2tt_trigger_pulser: directed stimulus with a cycle-indexed reference model of the pulser
module tb_b2tt_trigger_pulser;
  logic clock = 0, reset = 1, trg = 0, frame9 = 0, clear_counts = 0;
  logic [15:0] delay = 0, holdoff = 0, gate_start = 0, gate_end = 16'hffff;
  logic [7:0] width = 1;
  logic pulse, busy;
  logic [31:0] accepted_count;
  logic [1:0] dropped_count;
  int tests = 0, fails = 0, n = 0;

  b2tt_trigger_pulser #(.DROP_BITS(2)) dut (
    .clock(clock), .reset(reset), .trg(trg), .frame9(frame9),
    .delay(delay), .width(width), .holdoff(holdoff),
    .gate_start(gate_start), .gate_end(gate_end), .clear_counts(clear_counts),
    .pulse(pulse), .busy(busy), .accepted_count(accepted_count), .dropped_count(dropped_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) n <= n + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, n);
    end
  endtask

  // Reference model: an accepted trigger at edge k owns the busy window
  // [k, k+d+w+h-1] and drives pulse over edges [k+d+1, k+d+w].
  int m_blo = 0, m_bhi = -2, m_plo = 0, m_phi = -1, m_drop = 0;
  longint m_acc = 0;
  bit exp_pulse = 0, exp_busy = 0;
`ifdef FRAME_GATE_EN
  int m_frame = -1000000;
`endif

  initial begin : model
    int dd, ww;
    bit ok;
`ifdef FRAME_GATE_EN
    int ph;
`endif
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        m_blo = 0; m_bhi = -2; m_plo = 0; m_phi = -1;
        m_acc = 0; m_drop = 0; exp_pulse = 0; exp_busy = 0;
      end else begin
`ifdef FRAME_GATE_EN
        ph = frame9 ? 0 : ((n - m_frame > 65535) ? 65535 : n - m_frame);
        if (frame9) m_frame = n;
        ok = trg && (n - 1 > m_bhi) && ph >= int'(gate_start) && ph <= int'(gate_end);
`else
        ok = trg && (n - 1 > m_bhi);
`endif
        if (ok) begin
          dd = int'(delay);
          ww = (width == 0) ? 1 : int'(width);
          m_blo = n;
          m_bhi = n + dd + ww + int'(holdoff) - 1;
          m_plo = n + dd + 1;
          m_phi = n + dd + ww;
        end
        if (clear_counts) begin m_acc = 0; m_drop = 0; end
        else if (ok) m_acc++;
        else if (trg && m_drop < 3) m_drop++;
        exp_pulse = n >= m_plo && n <= m_phi;
        exp_busy = n >= m_blo && n <= m_bhi;
      end
    end
  end

  initial forever begin
    @(negedge clock);
    chk("pulse", pulse, exp_pulse);
    chk("busy", busy, exp_busy);
    chk("accepted", accepted_count, m_acc);
    chk("dropped", dropped_count, m_drop);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic cfg(input int d, input int w, input int h);
    delay = 16'(d); width = 8'(w); holdoff = 16'(h);
  endtask

  task automatic fire(output int k);
    @(negedge clock);
    trg = 1; k = n;
    @(negedge clock);
    trg = 0;
  endtask

  task automatic wait_pulse(input int k, output int rise, output int len);
    rise = -1; len = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (pulse) begin
        if (rise < 0) rise = n - 1 - k;
        len++;
      end else if (rise >= 0) break;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500 && busy; i++) @(negedge clock);
    chk("idle_timeout", busy, 0);
  endtask

  task automatic do_clear();
    @(negedge clock); clear_counts = 1;
    @(negedge clock); clear_counts = 0;
    chk("clr_acc", accepted_count, 0);
    chk("clr_drop", dropped_count, 0);
  endtask

  initial begin
    int k, rise, len;
    repeat (3) @(negedge clock);
    chk("rst_pulse", pulse, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acc", accepted_count, 0);
    chk("rst_drop", dropped_count, 0);
    reset = 0;
    cfg(5, 3, 0);
    do_clear();
    fire(k);
    cfg(1, 9, 7);
    wait_pulse(k, rise, len);
    chk("t1_rise", rise, 6);
    chk("t1_len", len, 3);
    chk("t1_acc", accepted_count, 1);
    chk("t1_drop", dropped_count, 0);
    wait_idle();
    cfg(0, 0, 0);
    fire(k);
    wait_pulse(k, rise, len);
    chk("t2_rise", rise, 1);
    chk("t2_len", len, 1);
    wait_idle();
    cfg(2, 4, 10);
    do_clear();
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (i == 20) chk("t3_gap", pulse, 0);
      if (i == 21) chk("t3_rise2", pulse, 1);
      trg = (i == 0 || i == 3 || i == 17);
    end
    trg = 0;
    wait_idle();
    chk("t3_acc", accepted_count, 2);
    chk("t3_drop", dropped_count, 1);
    cfg(50, 1, 0);
    do_clear();
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      trg = (i % 2 == 0);
    end
    trg = 0;
    @(negedge clock);
    chk("t4_acc", accepted_count, 1);
    chk("t4_sat", dropped_count, 3);
    wait_idle();
    cfg(3, 1, 0);
    @(negedge clock);
    trg = 1; clear_counts = 1;
    @(negedge clock);
    trg = 0; clear_counts = 0;
    chk("t4_clr_acc", accepted_count, 0);
    chk("t4_clr_drop", dropped_count, 0);
    chk("t4_clr_busy", busy, 1);
    wait_idle();
    cfg(0, 20, 0);
    fire(k);
    for (int i = 0; i < 10 && !pulse; i++) @(negedge clock);
    repeat (7) @(negedge clock);
    chk("t5_mid", pulse, 1);
    #2 reset = 1;
    #1;
    chk("t5_rst_pulse", pulse, 0);
    chk("t5_rst_busy", busy, 0);
    @(negedge clock);
    reset = 0;
    fire(k);
    wait_pulse(k, rise, len);
    chk("t5_rise", rise, 1);
    chk("t5_len", len, 20);
    wait_idle();
`ifdef FRAME_GATE_EN
    cfg(0, 1, 0);
    gate_start = 100; gate_end = 200;
    do_clear();
    for (int i = 0; i < 206; i++) begin
      @(negedge clock);
      frame9 = (i == 0);
      trg = (i == 99 || i == 100 || i == 200 || i == 202);
    end
    frame9 = 0; trg = 0;
    @(negedge clock);
    chk("t6_acc", accepted_count, 2);
    chk("t6_drop", dropped_count, 2);
`endif
    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
